pad_block: RTL and testbench

PAD_BLOCK -- requirements
Module: pad_block

---
 rtl/ascon_pack.sv | 8 +
 rtl/pad_mask.sv | 24 ++
 rtl/pad_block.sv | 90 +++++++++
 tb/tb_pad_block.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pack.sv
// Shared types and constants for the Ascon message padding front end.
package ascon_pack;

    typedef enum logic {ACCEPT, EXTRA} type_pad_state;

    localparam logic [63:0] PAD_WORD = 64'h8000_0000_0000_0000;

endpackage

// File: rtl/pad_mask.sv
// Combinational padder: keeps the first nbytes bytes of an MSB-first word,
// appends the 0x80 delimiter and zero-fills; counts of 8 or more pass data through.
module pad_mask
    import ascon_pack::*;
(
    input  logic [63:0] data,
    input  logic [3:0]  nbytes,
    output logic [63:0] padded
);

    logic [5:0] shamt;

    always_comb begin
        shamt = {nbytes[2:0], 3'b000};
        if (nbytes >= 4'd8) begin
            padded = data;
        end else begin
            // Bytes are MSB-first, so a right shift by 8*n moves both the keep
            // boundary and the delimiter to byte n.
            padded = (data & ~({64{1'b1}} >> shamt)) | (PAD_WORD >> shamt);
        end
    end

endmodule

// File: rtl/pad_block.sv
// Ascon rate padding stage: turns a stream of message words into padded
// 64-bit blocks behind a single output register with valid/ready handshakes.
module pad_block
    import ascon_pack::*;
#(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic [63:0]          data_i,
    input  logic [3:0]           bytes_i,
    input  logic                 last_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic [63:0]          block_o,
    output logic                 block_valid_o,
    output logic                 block_last_o,
    input  logic                 block_ready_i,
    output logic [CNT_WIDTH-1:0] block_cnt_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_WIDTH'(1);
    endfunction

    type_pad_state          state;
    logic                   cnt_clr;
    logic                   slot_free;
    logic                   in_xfer;
    logic                   out_xfer;
    logic                   short_last;
    logic [3:0]             mask_bytes;
    logic [63:0]            padded;
    logic [CNT_WIDTH-1:0]   cnt_base;

    assign slot_free  = !block_valid_o || block_ready_i;
    assign ready_o    = (state == ACCEPT) && slot_free && !reset_i;
    assign in_xfer    = valid_i && ready_o;
    assign out_xfer   = block_valid_o && block_ready_i;
    assign short_last = last_i && (bytes_i < 4'd8);
    // Non-final words are forwarded untouched regardless of bytes_i.
    assign mask_bytes = last_i ? bytes_i : 4'd8;
    // The counter shows the final count for one cycle after a message ends.
    assign cnt_base   = cnt_clr ? '0 : block_cnt_o;

    pad_mask u_pad_mask (
        .data   (data_i),
        .nbytes (mask_bytes),
        .padded (padded)
    );

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state         <= ACCEPT;
            block_o       <= '0;
            block_valid_o <= 1'b0;
            block_last_o  <= 1'b0;
            block_cnt_o   <= '0;
            cnt_clr       <= 1'b0;
        end else begin
            if (out_xfer) begin
                block_cnt_o <= sat_inc(cnt_base);
                cnt_clr     <= block_last_o;
            end else begin
                block_cnt_o <= cnt_base;
                cnt_clr     <= 1'b0;
            end

            if (in_xfer) begin
                block_o       <= padded;
                block_last_o  <= short_last;
                block_valid_o <= 1'b1;
                if (last_i && !short_last) begin
                    state <= EXTRA;
                end
            end else if (state == EXTRA && slot_free) begin
                // A full final word still owes a block holding only the delimiter.
                block_o       <= PAD_WORD;
                block_last_o  <= 1'b1;
                block_valid_o <= 1'b1;
                state         <= ACCEPT;
            end else if (out_xfer) begin
                block_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pad_block.sv
// Bench for pad_block: directed message vectors, a queue-based model of the
// expected block stream, and literal checks of the recorded output stream.
module tb_pad_block;

    localparam int CW = 3;
    localparam logic [63:0] PAD = 64'h8000_0000_0000_0000;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset_i;
    logic [63:0]   data_i;
    logic [3:0]    bytes_i;
    logic          last_i;
    logic          valid_i;
    logic          ready_o;
    logic [63:0]   block_o;
    logic          block_valid_o;
    logic          block_last_o;
    logic          block_ready_i;
    logic [CW-1:0] block_cnt_o;

    pad_block #(.CNT_WIDTH(CW)) dut (
        .clock_i       (clk),
        .reset_i       (reset_i),
        .data_i        (data_i),
        .bytes_i       (bytes_i),
        .last_i        (last_i),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .block_o       (block_o),
        .block_valid_o (block_valid_o),
        .block_last_o  (block_last_o),
        .block_ready_i (block_ready_i),
        .block_cnt_o   (block_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] d;
        logic        l;
    } blk_t;

    int          n_checks = 0;
    int          n_bad = 0;
    int          cyc = 0;
    blk_t        q[$];
    logic [63:0] log_data[$];
    logic        log_last[$];
    int          log_cyc[$];
    int          log_cnt[$];
    int          m_cnt = 0;
    bit          m_clr = 1'b0;
    bit          started = 1'b0;
    bit          prev_xfer = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Padding rule stated byte by byte: keep n message bytes, then 0x80, then zeros.
    function automatic logic [63:0] pad_ref(input logic [63:0] d, input int n);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < n)       r[63-8*i -: 8] = d[63-8*i -: 8];
            else if (i == n) r[63-8*i -: 8] = 8'h80;
        end
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Model: expected block stream as a queue, compared every cycle.
    always @(negedge clk) begin
        bit hl;
        int base;
        if (reset_i) begin
            if (started) chk("ready_in_reset", {63'd0, ready_o}, 64'd0);
            q.delete();
            m_cnt = 0;
            m_clr = 1'b0;
            prev_xfer = 1'b0;
            started = 1'b1;
        end else if (started) begin
            chk("valid_vs_pending", {63'd0, block_valid_o}, {63'd0, q.size() > 0});
            if (block_valid_o && q.size() > 0) begin
                chk("block_data", block_o, q[0].d);
                chk("block_last", {63'd0, block_last_o}, {63'd0, q[0].l});
            end
            chk("block_cnt", 64'(block_cnt_o), 64'(m_cnt));
            if (block_valid_o && !block_ready_i)
                chk("ready_while_stalled", {63'd0, ready_o}, 64'd0);
            if (prev_xfer) log_cnt.push_back(int'(block_cnt_o));

            base = m_clr ? 0 : m_cnt;
            if (block_valid_o && block_ready_i) begin
                hl = (q.size() > 0) ? q[0].l : 1'b0;
                log_data.push_back(block_o);
                log_last.push_back(block_last_o);
                log_cyc.push_back(cyc);
                if (q.size() > 0) void'(q.pop_front());
                m_cnt = (base >= CMAX) ? CMAX : base + 1;
                m_clr = hl;
                prev_xfer = 1'b1;
            end else begin
                m_cnt = base;
                m_clr = 1'b0;
                prev_xfer = 1'b0;
            end

            if (valid_i && ready_o) begin
                if (!last_i) begin
                    q.push_back('{d: data_i, l: 1'b0});
                end else if (bytes_i < 8) begin
                    q.push_back('{d: pad_ref(data_i, int'(bytes_i)), l: 1'b1});
                end else begin
                    q.push_back('{d: data_i, l: 1'b0});
                    q.push_back('{d: PAD, l: 1'b1});
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [63:0] d, input logic [3:0] b, input logic l);
        bit got;
        got = 1'b0;
        data_i  = d;
        bytes_i = b;
        last_i  = l;
        valid_i = 1'b1;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            got = ready_o;
            @(posedge clk);
            #1;
        end
        if (!got) begin
            n_checks++;
            n_bad++;
            $display("FAIL send_timeout: word %h not accepted within 50 cycles", d);
        end
        valid_i = 1'b0;
    endtask

    task automatic clear_log();
        log_data.delete();
        log_last.delete();
        log_cyc.delete();
        log_cnt.delete();
    endtask

    task automatic chk_log(input string name, input int idx, input logic [63:0] d, input logic l);
        if (idx < log_data.size()) begin
            chk(name, log_data[idx], d);
            chk({name, "_last"}, {63'd0, log_last[idx]}, {63'd0, l});
        end else begin
            chk({name, "_missing"}, 64'(log_data.size()), 64'(idx + 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i = 1'b1;
        valid_i = 1'b0;
        data_i = '0;
        bytes_i = '0;
        last_i = 1'b0;
        block_ready_i = 1'b1;

        // Reset state
        idle(2);
        @(negedge clk);
        chk("ready_during_reset", {63'd0, ready_o}, 64'd0);
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        @(negedge clk);
        chk("rst_valid", {63'd0, block_valid_o}, 64'd0);
        chk("rst_block", block_o, 64'd0);
        chk("rst_last", {63'd0, block_last_o}, 64'd0);
        chk("rst_cnt", 64'(block_cnt_o), 64'd0);
        chk("rst_ready", {63'd0, ready_o}, 64'd1);
        @(posedge clk);
        #1;

        // Two full words, the second final: extra pad block follows
        clear_log();
        send(64'h0011_2233_4455_6677, 4'd8, 1'b0);
        send(64'h8899_AABB_CCDD_EEFF, 4'd8, 1'b1);
        idle(4);
        chk_log("full_w0", 0, 64'h0011_2233_4455_6677, 1'b0);
        chk_log("full_w1", 1, 64'h8899_AABB_CCDD_EEFF, 1'b0);
        chk_log("full_pad", 2, PAD, 1'b1);
        for (int i = 0; i < 3; i++)
            if (i < log_cnt.size()) chk("full_cnt", 64'(log_cnt[i]), 64'(i + 1));
        chk("full_cnt_nlog", 64'(log_cnt.size()), 64'd3);
        chk("full_cnt_after", 64'(block_cnt_o), 64'd0);

        // Short final word, including trailing garbage that must be masked
        clear_log();
        send(64'h4142_4300_0000_0000, 4'd3, 1'b1);
        send(64'h4142_43FF_FFFF_FFFF, 4'd3, 1'b1);
        send(64'h1234_5678_9ABC_DEF0, 4'd0, 1'b1);
        send(64'hFFFF_FFFF_FFFF_FFFF, 4'd7, 1'b1);
        send(64'h1122_3344_5566_7788, 4'd2, 1'b0);
        send(64'h0123_4567_89AB_CDEF, 4'd12, 1'b1);
        idle(4);
        chk_log("short3", 0, 64'h4142_4380_0000_0000, 1'b1);
        chk_log("short3_mask", 1, 64'h4142_4380_0000_0000, 1'b1);
        chk_log("empty_msg", 2, PAD, 1'b1);
        chk_log("short7", 3, 64'hFFFF_FFFF_FFFF_FF80, 1'b1);
        chk_log("nonlast_bytes_ignored", 4, 64'h1122_3344_5566_7788, 1'b0);
        chk_log("bytes12_word", 5, 64'h0123_4567_89AB_CDEF, 1'b0);
        chk_log("bytes12_pad", 6, PAD, 1'b1);
        chk("short_nblocks", 64'(log_data.size()), 64'd7);

        // Backpressure for three cycles, then back-to-back stream
        clear_log();
        block_ready_i = 1'b0;
        send(64'hA0A0_A0A0_A0A0_A0A0, 4'd8, 1'b0);
        data_i = 64'hB1B1_B1B1_B1B1_B1B1;
        bytes_i = 4'd8;
        last_i = 1'b0;
        valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_ready", {63'd0, ready_o}, 64'd0);
            chk("stall_block", block_o, 64'hA0A0_A0A0_A0A0_A0A0);
            chk("stall_valid", {63'd0, block_valid_o}, 64'd1);
            @(posedge clk);
            #1;
        end
        block_ready_i = 1'b1;
        send(64'hB1B1_B1B1_B1B1_B1B1, 4'd8, 1'b0);
        send(64'hC2C2_C2C2_C2C2_C2C2, 4'd8, 1'b0);
        send(64'hD3D3_D3D3_D3D3_D3D3, 4'd8, 1'b1);
        idle(4);
        chk_log("bp_w0", 0, 64'hA0A0_A0A0_A0A0_A0A0, 1'b0);
        chk_log("bp_w3", 3, 64'hD3D3_D3D3_D3D3_D3D3, 1'b0);
        chk_log("bp_pad", 4, PAD, 1'b1);
        if (log_cyc.size() == 5) begin
            for (int i = 0; i < 4; i++)
                chk("bp_back_to_back", 64'(log_cyc[i+1] - log_cyc[i]), 64'd1);
        end else begin
            chk("bp_nblocks", 64'(log_cyc.size()), 64'd5);
        end

        // Reset while a pad block is still owed
        clear_log();
        block_ready_i = 1'b0;
        send(64'hEEEE_EEEE_EEEE_EEEE, 4'd8, 1'b1);
        idle(1);
        reset_i = 1'b1;
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        @(negedge clk);
        chk("rstx_valid", {63'd0, block_valid_o}, 64'd0);
        chk("rstx_cnt", 64'(block_cnt_o), 64'd0);
        chk("rstx_ready", {63'd0, ready_o}, 64'd1);
        @(posedge clk);
        #1;
        block_ready_i = 1'b1;
        idle(4);
        chk("rstx_no_pad", 64'(log_data.size()), 64'd0);

        // Counter saturation over a long message
        clear_log();
        for (int i = 0; i < 10; i++) send(64'(i + 1), 4'd8, 1'b0);
        send(64'h5555_0000_0000_0000, 4'd2, 1'b1);
        idle(4);
        chk("sat_nlog", 64'(log_cnt.size()), 64'd11);
        for (int i = 0; i < log_cnt.size(); i++)
            chk("sat_cnt", 64'(log_cnt[i]), 64'((i + 1 > CMAX) ? CMAX : i + 1));
        chk_log("sat_last", 10, 64'h5555_8000_0000_0000, 1'b1);
        chk("sat_cnt_after", 64'(block_cnt_o), 64'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
